// File: rtl/carfield_llc_cdc_dst.sv
// carfield_llc_cdc_dst
// Read side of one gray-pointer async FIFO channel on the LLC/DRAM path.
// It lives in the DRAM clock domain and does the following:
//   - samples the source's gray write pointer through a synchronizer,
//   - reads the head entry straight out of the source-owned storage array,
//   - returns its own gray read pointer to the source.
// Optional macro CARFIELD_LLC_CDC_DST_SPILL_EN inserts a one-entry
// registered output stage in front of data_o/valid_o.
module carfield_llc_cdc_dst #(
    parameter int unsigned LogDepth   = 3,
    parameter int unsigned Width      = 64,
    parameter int unsigned SyncStages = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [(2**LogDepth)*Width-1:0]  data_i,
    input  logic [LogDepth:0]               wptr_i,
    output logic [LogDepth:0]               rptr_o,
    output logic [Width-1:0]                data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [LogDepth:0]               count_o,
    output logic                            err_o
);

    localparam int unsigned Depth = 2 ** LogDepth;
    localparam int unsigned PtrW  = LogDepth + 1;

    typedef logic [PtrW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = 1; i < int'(PtrW); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    ptr_t             sync_q [SyncStages];
    ptr_t             sync_d [SyncStages];
    ptr_t             wsync_prev_q, wsync_prev_d;
    ptr_t             rptr_bin_q, rptr_bin_d;
    ptr_t             rptr_gray_q, rptr_gray_d;
    ptr_t             count_q, count_d;
    logic             err_q, err_d;

    ptr_t             wptr_sync;
    ptr_t             wptr_bin;
    ptr_t             wptr_bin_next;
    ptr_t             level;
    ptr_t             wsync_diff;
    logic [LogDepth-1:0] rptr_idx;
    logic [Width-1:0] head_data;
    logic             fifo_valid;
    logic             fifo_ready;
    logic             fifo_pop;

`ifdef CARFIELD_LLC_CDC_DST_SPILL_EN
    logic             spill_full_q, spill_full_d;
    logic [Width-1:0] spill_data_q, spill_data_d;
`endif

    // Write-pointer synchronizer shift chain, stage 0 samples the async input
    always_comb begin
        for (int i = 0; i < int'(SyncStages); i++) begin
            sync_d[i] = '0;
        end
        sync_d[0] = wptr_i;
        for (int i = 1; i < int'(SyncStages); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Head selection straight from the source's storage at the read index
    always_comb begin
        wptr_sync  = sync_q[SyncStages-1];
        wptr_bin   = gray2bin(wptr_sync);
        rptr_idx   = rptr_bin_q[LogDepth-1:0];
        fifo_valid = (wptr_sync != bin2gray(rptr_bin_q));
        head_data  = '0;
        for (int k = 0; k < int'(Depth); k++) begin
            if (rptr_idx == LogDepth'(k)) begin
                head_data = data_i[k*Width +: Width];
            end
        end
    end

`ifdef CARFIELD_LLC_CDC_DST_SPILL_EN
    // Spill stage refills in the same cycle it drains, so throughput stays full
    always_comb begin
        fifo_ready   = !spill_full_q || ready_i;
        fifo_pop     = fifo_valid && fifo_ready;
        spill_full_d = spill_full_q;
        spill_data_d = spill_data_q;
        if (fifo_pop) begin
            spill_full_d = 1'b1;
            spill_data_d = head_data;
        end else if (ready_i) begin
            spill_full_d = 1'b0;
        end
        valid_o = spill_full_q;
        data_o  = spill_data_q;
    end
`else
    // Head entry is presented directly; valid never looks at ready
    always_comb begin
        fifo_ready = ready_i;
        fifo_pop   = fifo_valid && fifo_ready;
        valid_o    = fifo_valid;
        data_o     = head_data;
    end
`endif

    // Read pointer advance, fill level and sticky corruption detection
    always_comb begin
        rptr_bin_d    = rptr_bin_q + ptr_t'(fifo_pop);
        rptr_gray_d   = bin2gray(rptr_bin_d);
        wptr_bin_next = gray2bin(sync_d[SyncStages-1]);
        count_d       = wptr_bin_next - rptr_bin_d;
        level         = wptr_bin - rptr_bin_q;
        wsync_diff    = wptr_sync ^ wsync_prev_q;
        wsync_prev_d  = wptr_sync;
        err_d         = err_q;
        if (level > ptr_t'(Depth)) begin
            err_d = 1'b1;
        end
        if ((wsync_diff & (wsync_diff - ptr_t'(1))) != '0) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SyncStages); i++) begin
                sync_q[i] <= '0;
            end
            wsync_prev_q <= '0;
            rptr_bin_q   <= '0;
            rptr_gray_q  <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SyncStages); i++) begin
                sync_q[i] <= sync_d[i];
            end
            wsync_prev_q <= wsync_prev_d;
            rptr_bin_q   <= rptr_bin_d;
            rptr_gray_q  <= rptr_gray_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

`ifdef CARFIELD_LLC_CDC_DST_SPILL_EN
    // Output stage registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spill_full_q <= 1'b0;
            spill_data_q <= '0;
        end else begin
            spill_full_q <= spill_full_d;
            spill_data_q <= spill_data_d;
        end
    end
`endif

    assign rptr_o  = rptr_gray_q;
    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_carfield_llc_cdc_dst.sv
// Testbench for carfield_llc_cdc_dst: directed vectors, scoreboard-checked data order.
module tb_carfield_llc_cdc_dst;

    localparam int LOG_DEPTH = 3;
    localparam int DEPTH     = 8;
    localparam int WIDTH     = 64;
    localparam int SYNC      = 2;
    localparam int PTRW      = 4;
`ifdef CARFIELD_LLC_CDC_DST_SPILL_EN
    localparam int SPILL = 1;
`else
    localparam int SPILL = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_i = 1'b1;
    logic [DEPTH*WIDTH-1:0]   data_i = '0;
    logic [PTRW-1:0]          wptr_i = '0;
    logic [PTRW-1:0]          rptr_o;
    logic [WIDTH-1:0]         data_o;
    logic                     valid_o;
    logic                     ready_i = 1'b0;
    logic [PTRW-1:0]          count_o;
    logic                     err_o;

    int                       vectors = 0;
    int                       miscompares = 0;
    logic [63:0]              exp_q[$];
    logic [PTRW-1:0]          wbin = '0;
    logic [PTRW-1:0]          prev_r;
    logic [63:0]              bp_vals [4];
    logic                     hold_v = 1'b0;
    logic [63:0]              hold_d = '0;

    carfield_llc_cdc_dst #(
        .LogDepth  (LOG_DEPTH),
        .Width     (WIDTH),
        .SyncStages(SYNC)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .data_i (data_i),
        .wptr_i (wptr_i),
        .rptr_o (rptr_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .count_o(count_o),
        .err_o  (err_o)
    );

    // Free-running DRAM-domain clock
    always #5 clk = ~clk;

    function automatic logic [PTRW-1:0] to_gray(input logic [PTRW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source-side write: store the entry, advance the gray pointer, expect it later
    task automatic applyStimulus(input logic [63:0] value);
        data_i[int'(wbin[LOG_DEPTH-1:0])*WIDTH +: WIDTH] = value;
        wbin   = wbin + 1'b1;
        wptr_i = to_gray(wbin);
        exp_q.push_back(value);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((valid_o || count_o != 0 || exp_q.size() != 0) && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_timeout"}, 64'(n >= 64), 64'(0));
        checkOutput({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
        checkOutput({name, "_count"}, 64'(count_o), 64'(0));
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold stability
    always @(negedge clk) begin
        if (rst_i) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checkOutput("hold_valid", 64'(valid_o), 64'(1));
                checkOutput("hold_data", data_o, hold_d);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) checkOutput("sb_underflow", 64'(1), 64'(0));
                else checkOutput("sb_data", data_o, exp_q.pop_front());
            end
            hold_v = valid_o && !ready_i;
            hold_d = data_o;
        end
    end

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Directed test sequence
    initial begin
        bp_vals[0] = 64'hAAAA_0000_0000_000A;
        bp_vals[1] = 64'hBBBB_0000_0000_000B;
        bp_vals[2] = 64'hCCCC_0000_0000_000C;
        bp_vals[3] = 64'hDDDD_0000_0000_000D;

        // Reset with random write pointer
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wptr_i = PTRW'($urandom);
            tick();
        end
        rst_i  = 1'b0;
        wptr_i = '0;
        wbin   = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 64'(valid_o), 64'(0));
        checkOutput("rst_rptr", 64'(rptr_o), 64'(0));
        checkOutput("rst_count", 64'(count_o), 64'(0));
        checkOutput("rst_err", 64'(err_o), 64'(0));

        // Single entry latency
        tick();
        ready_i = 1'b1;
        applyStimulus(64'h0000_0000_DEAD_BEEF);
        for (int c = 0; c <= 2 + SPILL; c++) begin
            @(negedge clk);
            checkOutput("se_valid", 64'(valid_o), 64'(c == 2 + SPILL));
        end
        checkOutput("se_data", data_o, 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        checkOutput("se_rptr", 64'(rptr_o), 64'(4'b0001));
        checkOutput("se_valid_drop", 64'(valid_o), 64'(0));
        checkOutput("se_count", 64'(count_o), 64'(0));

        // Backpressure: four entries held for ten cycles
        tick();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bp_vals[i]);
            tick();
        end
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_data", data_o, bp_vals[0]);
            checkOutput("bp_count", 64'(count_o), 64'(4 - SPILL));
        end
        tick();
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_stream_valid", 64'(valid_o), 64'(1));
        end
        @(negedge clk);
        checkOutput("bp_done_valid", 64'(valid_o), 64'(0));
        waitDrain("bp");

        // Wrap-around: twenty writes and pops across the pointer MSB
        tick();
        prev_r = rptr_o;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(64'hC0DE_0000_0000_0000 | 64'(i));
            @(negedge clk);
            checkOutput("wrap_rptr_onebit", 64'($countones(rptr_o ^ prev_r) > 1), 64'(0));
            prev_r = rptr_o;
            tick();
        end
        waitDrain("wrap");
        checkOutput("wrap_rptr_final", 64'(rptr_o), 64'(to_gray(wbin)));

        // Simultaneous pop and write pointer advance
        tick();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(64'h5151_0000_0000_0000 | 64'(i));
            tick();
        end
        repeat (4) tick();
        @(negedge clk);
        checkOutput("sim_count_pre", 64'(count_o), 64'(3 - SPILL));
        tick();
        applyStimulus(64'h5151_0000_0000_0003);
        tick();
        ready_i = 1'b1;
        @(negedge clk);
        checkOutput("sim_count_before", 64'(count_o), 64'(3 - SPILL));
        tick();
        ready_i = 1'b0;
        @(negedge clk);
        checkOutput("sim_count_after", 64'(count_o), 64'(3 - SPILL));
        tick();
        ready_i = 1'b1;
        waitDrain("sim");

        // Reset mid-operation drops in-flight entries
        tick();
        ready_i = 1'b0;
        applyStimulus(64'h7777_0000_0000_0001);
        applyStimulus(64'h7777_0000_0000_0002);
        tick();
        tick();
        rst_i  = 1'b1;
        wptr_i = '0;
        wbin   = '0;
        exp_q.delete();
        tick();
        @(negedge clk);
        checkOutput("mid_rst_rptr", 64'(rptr_o), 64'(0));
        checkOutput("mid_rst_valid", 64'(valid_o), 64'(0));
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_count", 64'(count_o), 64'(0));

        // Overflow: write pointer nine ahead of an empty reader
        tick();
        wptr_i = to_gray(4'd9);
        for (int c = 0; c <= SYNC + 1; c++) begin
            @(negedge clk);
            checkOutput("ovf_err", 64'(err_o), 64'(c == SYNC + 1));
        end
        tick();
        wptr_i = to_gray(4'd8);
        repeat (4) tick();
        @(negedge clk);
        checkOutput("ovf_sticky", 64'(err_o), 64'(1));
        tick();
        rst_i  = 1'b1;
        wptr_i = '0;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("ovf_rst_clear", 64'(err_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
